fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the pipelined RISC-V core. It owns the fetch PC, issues one-at-a-time requests to the instruction memory over a valid/ready handshake, and buffers the returned instruction and its PC for the decode stage. It applies decode back-pressure (hazard stall) and branch/jump redirects, and discards stale responses after a redirect. It replaces the free-running PC/instr register pair in the CPU top.

---
 rtl/fetch_ctrl_pkg.sv | 15 +
 rtl/fetch_buf.sv | 56 +++++
 rtl/fetch_ctrl.sv | 110 +++++++++++
 tb/tb_fetch_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared widths, reset PC, PC increment and FSM encoding for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int INSTR_WIDTH = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int PC_INCR = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// One-entry holding register between instruction memory and decode.
// Flush beats fill, and fill beats drain, so a same-edge fill and drain keeps the new entry.
module fetch_buf
    import fetch_ctrl_pkg::*;
#(
    parameter int AddrWidth  = ADDR_WIDTH,
    parameter int InstrWidth = INSTR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fill,
    input  logic                  drain,
    input  logic                  flush,
    input  logic [InstrWidth-1:0] fill_instr,
    input  logic [AddrWidth-1:0]  fill_pc,
    output logic                  valid,
    output logic [InstrWidth-1:0] instr,
    output logic [AddrWidth-1:0]  pc
);

    logic                  valid_q, valid_d;
    logic [InstrWidth-1:0] instr_q, instr_d;
    logic [AddrWidth-1:0]  pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (fill) begin
            valid_d = 1'b1;
            instr_d = fill_instr;
            pc_d    = fill_pc;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, keeps at most one memory request
// outstanding, and discards responses that a redirect has made stale.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int AddrWidth  = ADDR_WIDTH,
    parameter int InstrWidth = INSTR_WIDTH,
    parameter logic [AddrWidth-1:0] RESET_PC = AddrWidth'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [AddrWidth-1:0]  imem_req_addr,
    input  logic                  imem_rsp_valid,
    output logic                  imem_rsp_ready,
    input  logic [InstrWidth-1:0] imem_rsp_instr,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [InstrWidth-1:0] if_instr,
    output logic [AddrWidth-1:0]  if_pc,
    input  logic                  redirect,
    input  logic [AddrWidth-1:0]  redirect_pc
);

    fetch_state_e         state_q, state_d;
    logic [AddrWidth-1:0] fpc_q, fpc_d;
    logic [AddrWidth-1:0] inflight_pc_q, inflight_pc_d;
    logic [AddrWidth-1:0] req_addr_q, req_addr_d;
    logic                 kill_q, kill_d;
    logic                 req_valid_q, req_valid_d;
    logic                 req_fire, rsp_fire, buf_fill, buf_valid;

    assign imem_rsp_ready = kill_q | ~buf_valid | if_ready;
    assign req_fire       = req_valid_q & imem_req_ready;
    assign rsp_fire       = (state_q == WAIT) & imem_rsp_valid & imem_rsp_ready;
    assign buf_fill       = rsp_fire & ~kill_q & ~redirect;

    always_comb begin
        state_d       = state_q;
        fpc_d         = fpc_q;
        inflight_pc_d = inflight_pc_q;
        kill_d        = kill_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (req_fire) begin
                    inflight_pc_d = fpc_q;
                    fpc_d         = fpc_q + AddrWidth'(PC_INCR);
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                if (rsp_fire) begin
                    kill_d  = 1'b0;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        // A redirect that leaves a request outstanding marks its eventual response stale.
        if (redirect) begin
            fpc_d = redirect_pc & ~AddrWidth'(3);
            if (state_d == WAIT) begin
                kill_d = 1'b1;
            end
        end
        req_valid_d = (state_d == REQ);
        req_addr_d  = fpc_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            fpc_q         <= RESET_PC;
            inflight_pc_q <= '0;
            kill_q        <= 1'b0;
            req_valid_q   <= 1'b0;
            req_addr_q    <= RESET_PC;
        end else begin
            state_q       <= state_d;
            fpc_q         <= fpc_d;
            inflight_pc_q <= inflight_pc_d;
            kill_q        <= kill_d;
            req_valid_q   <= req_valid_d;
            req_addr_q    <= req_addr_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = req_addr_q;
    assign if_valid       = buf_valid;

    fetch_buf #(
        .AddrWidth  (AddrWidth),
        .InstrWidth (InstrWidth)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .fill       (buf_fill),
        .drain      (if_ready),
        .flush      (redirect),
        .fill_instr (imem_rsp_instr),
        .fill_pc    (inflight_pc_q),
        .valid      (buf_valid),
        .instr      (if_instr),
        .pc         (if_pc)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a reference stream of expected PCs (restarted on reset or
// redirect) is popped by a monitor whenever decode consumes an instruction.
module tb_fetch_ctrl;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, redirect, if_ready;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid, imem_rsp_ready, if_valid;
    logic [31:0] imem_req_addr, imem_rsp_instr, if_instr, if_pc, redirect_pc;

    int nCompared   = 0;
    int nMismatched = 0;
    int nDelivered  = 0;
    int readyPct    = 100;
    int memMinLat   = 0;
    int memMaxLat   = 0;

    logic [31:0] expQ[$];
    logic [31:0] reqLog[$];
    logic [31:0] nextPc = TB_RESET_PC;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .AddrWidth  (32),
        .InstrWidth (32),
        .RESET_PC   (TB_RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_ready (imem_rsp_ready),
        .imem_rsp_instr (imem_rsp_instr),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, pass the edge, then restart the expected stream if that edge
    // carried a reset or redirect. Returns #1 after the edge with outputs settled.
    task automatic applyStimulus(input logic rst, input logic rdr, input logic [31:0] rpc, input logic rdy);
        reset       = rst;
        redirect    = rdr;
        redirect_pc = rpc;
        if_ready    = rdy;
        @(posedge clk);
        #1;
        if (rst) begin
            expQ.delete();
            nextPc = TB_RESET_PC;
        end else if (rdr) begin
            expQ.delete();
            nextPc = rpc & ~32'h3;
        end
        while (expQ.size() < 8) begin
            expQ.push_back(nextPc);
            nextPc = nextPc + 32'd4;
        end
    endtask

    // Instruction memory: one request at a time, configurable latency and request back-pressure.
    initial begin : memory_model
        logic        rstS, hsS, rspS, outstanding;
        logic [31:0] hsAddr, pendAddr;
        int          latLeft;
        outstanding    = 1'b0;
        latLeft        = 0;
        pendAddr       = '0;
        hsAddr         = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_instr = '0;
        forever begin
            @(negedge clk);
            rstS   = reset;
            hsS    = imem_req_valid & imem_req_ready;
            rspS   = imem_rsp_valid & imem_rsp_ready;
            hsAddr = imem_req_addr;
            if (!rstS && hsS) begin
                reqLog.push_back(hsAddr);
                checkOutput("single_outstanding", 32'(outstanding), 32'h0);
            end
            @(posedge clk);
            #1;
            if (rstS) begin
                outstanding    = 1'b0;
                imem_rsp_valid = 1'b0;
            end else begin
                if (rspS) begin
                    outstanding    = 1'b0;
                    imem_rsp_valid = 1'b0;
                end
                if (hsS) begin
                    outstanding = 1'b1;
                    pendAddr    = hsAddr;
                    latLeft     = $urandom_range(memMinLat, memMaxLat);
                end
                if (outstanding && !imem_rsp_valid) begin
                    if (latLeft == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_instr = memWord(pendAddr);
                    end else begin
                        latLeft--;
                    end
                end
            end
            imem_req_ready = ($urandom_range(0, 99) < readyPct);
        end
    end

    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!reset && if_valid && if_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("sb_underflow", 32'h1, 32'h0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sb_pc", if_pc, e);
                    checkOutput("sb_instr", if_instr, memWord(e));
                    nDelivered++;
                end
            end
        end
    end

    initial begin : main
        logic found;
        reset       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        if_ready    = 1'b0;

        // Reset held together with a redirect: reset values must win.
        repeat (3) applyStimulus(1'b1, 1'b1, 32'h0000_0300, 1'b0);
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'h0);
        checkOutput("rst_req_addr", imem_req_addr, TB_RESET_PC);
        checkOutput("rst_if_valid", 32'(if_valid), 32'h0);
        checkOutput("rst_if_instr", if_instr, 32'h0);
        checkOutput("rst_if_pc", if_pc, 32'h0);
        checkOutput("rst_rsp_ready", 32'(imem_rsp_ready), 32'h1);

        // Zero-wait memory and ready decode: one instruction every second cycle.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            if (k == 0) begin
                checkOutput("first_req_valid", 32'(imem_req_valid), 32'h1);
                checkOutput("first_req_addr", imem_req_addr, TB_RESET_PC);
            end
            checkOutput("pipe_if_valid", 32'(if_valid), (k >= 2 && k % 2 == 0) ? 32'h1 : 32'h0);
        end

        // Decode stall: buffer stays full, response is back-pressured, no new request.
        repeat (5) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("stall_if_valid", 32'(if_valid), 32'h1);
        checkOutput("stall_rsp_ready", 32'(imem_rsp_ready), 32'h0);
        checkOutput("stall_req_valid", 32'(imem_req_valid), 32'h0);
        repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect to an unaligned target while a slow response is outstanding.
        memMinLat = 3;
        memMaxLat = 3;
        reqLog.delete();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            found = (reqLog.size() > 0);
        end
        checkOutput("wait_hs_seen", 32'(found), 32'h1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0103, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            found = if_valid;
        end
        checkOutput("redir_wait_seen", 32'(found), 32'h1);
        checkOutput("redir_wait_pc", if_pc, 32'h0000_0100);
        checkOutput("redir_wait_instr", if_instr, memWord(32'h0000_0100));

        // Redirect on the same edge as an accepted response.
        memMinLat = 0;
        memMaxLat = 0;
        reqLog.delete();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            found = (reqLog.size() > 0);
        end
        checkOutput("same_edge_hs_seen", 32'(found), 32'h1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        checkOutput("same_edge_if_valid", 32'(if_valid), 32'h0);
        checkOutput("same_edge_req_valid", 32'(imem_req_valid), 32'h1);
        checkOutput("same_edge_req_addr", imem_req_addr, 32'h0000_0200);

        // PC wrap at the top of the address space.
        readyPct  = 70;
        memMaxLat = 2;
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        reqLog.delete();
        for (int i = 0; i < 60 && reqLog.size() < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, ($urandom_range(0, 99) < 70));
        end
        checkOutput("wrap_req_count", 32'(reqLog.size() >= 2), 32'h1);
        if (reqLog.size() >= 2) begin
            checkOutput("wrap_req0", reqLog[0], 32'hFFFF_FFFC);
            checkOutput("wrap_req1", reqLog[1], 32'h0000_0000);
        end

        // Randomized traffic: back-pressure on both sides, variable latency, random redirects.
        for (int blk = 0; blk < 5; blk++) begin
            readyPct  = $urandom_range(40, 100);
            memMaxLat = $urandom_range(0, 3);
            for (int i = 0; i < 500; i++) begin
                logic        rdr;
                logic [31:0] rpc;
                rdr = ($urandom_range(0, 99) < 3);
                rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : ($urandom & 32'h0000_3FFF);
                applyStimulus(1'b0, rdr, rpc, ($urandom_range(0, 99) < 70));
            end
        end

        // Reset together with redirect in the middle of traffic.
        repeat (2) applyStimulus(1'b1, 1'b1, 32'h0000_0500, 1'b1);
        checkOutput("mid_rst_req_valid", 32'(imem_req_valid), 32'h0);
        checkOutput("mid_rst_req_addr", imem_req_addr, TB_RESET_PC);
        checkOutput("mid_rst_if_valid", 32'(if_valid), 32'h0);
        reqLog.delete();
        for (int i = 0; i < 30 && reqLog.size() == 0; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        end
        checkOutput("mid_rst_req_seen", 32'(reqLog.size() > 0), 32'h1);
        if (reqLog.size() > 0) begin
            checkOutput("mid_rst_first_req", reqLog[0], TB_RESET_PC);
        end
        repeat (20) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        checkOutput("deliveries", 32'(nDelivered > 100), 32'h1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
